ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (EX_A/EX_B operands, EX_rd, funct3).
- Runs MUL/MULH/MULHSU/MULHU in 2 cycles and DIV/DIVU/REM/REMU in 34 cycles.
- Raises md_stall so the hazard unit holds IF/ID and ID/EX while it works.
- Its result is muxed into the EX result path on md_done, and the instruction then advances to EX/MEM.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- DIV_CNT_W, 5, width of the division iteration counter

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high reset
- EX_md_valid  input  1  instruction currently in EX is an M-extension op
- EX_flush  input  1  kill the instruction in EX (branch/jump redirect)
- EX_funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- EX_A  input  32  rs1 operand after forwarding
- EX_B  input  32  rs2 operand after forwarding
- EX_rd  input  5  destination register
- md_stall  output  1  stall request to the hazard unit (combinational)
- md_done  output  1  one-cycle pulse: md_result is valid this cycle
- md_result  output  32  result
- md_rd  output  5  destination register of the completed op

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset state: state=IDLE. md_done=0, md_result=0, md_rd=0, md_stall=0, all internal registers 0.
- start = EX_md_valid && !EX_flush && state==IDLE.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - On start, latch funct3, EX_rd, and the operands.
  - funct3[2]=0 -> go to MUL.
  - DIV/DIVU/REM/REMU with EX_B==0 -> go to DONE with the special result.
  - DIV/REM with EX_A=0x80000000 and EX_B=0xFFFFFFFF -> go to DONE with the special result.
  - Any other divide -> latch |A| and |B| (raw values for unsigned ops), set counter=31, go to DIV.
- MUL: one cycle.
  - Registers the 64-bit product of 33-bit extended operands: A sign-extended for MUL/MULH/MULHSU, B sign-extended for MUL/MULH only, zero-extended otherwise.
  - Next state DONE.
- DIV: restoring radix-2, one quotient bit per cycle, MSB first.
  - Remainder register is 33 bits.
  - Each cycle: shift {rem, dividend} left by 1, trial-subtract the divisor, and keep the result if it is non-negative.
  - Counter decrements each cycle. When counter==0, go to FIX, for exactly 32 DIV cycles.
- FIX: one cycle.
  - Negate the quotient if the op is signed and sign(A)!=sign(B).
  - Negate the remainder if the op is signed and sign(A)=1.
  - Next state DONE.
- DONE: one cycle.
  - md_done=1.
  - md_result selection: MUL -> product[31:0]; MULH/MULHSU/MULHU -> product[63:32]; DIV/DIVU -> quotient; REM/REMU -> remainder.
  - md_rd=latched rd.
  - Next state IDLE.
  - EX_md_valid is ignored in DONE, so the op cannot restart.
- Stall: md_stall = start || state in {MUL, DIV, FIX}.
  - md_stall=0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency, counting the start cycle as cycle 0:
  - Multiply: md_done at cycle 2, md_stall high for cycles 0-1.
  - Normal divide: md_done at cycle 34, md_stall high for cycles 0-33.
  - Divide special case: md_done at cycle 1, md_stall high for cycle 0.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU), remainder=A.
  - Signed overflow: quotient=0x80000000, remainder=0.
- md_result and md_rd hold their value after DONE. md_done is 0 outside DONE.
- Flush: EX_flush=1 in MUL, DIV or FIX -> state=IDLE next cycle, no md_done, md_stall=0 from that next cycle.
  - EX_flush and EX_md_valid together in IDLE -> no start; flush wins.
  - EX_flush in DONE has no effect; the result is already committed.
- Reset mid-operation: returns to the reset state next cycle, and the in-flight op is discarded.
- Back-to-back ops: a new start is accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 localparams: MD_MUL … MD_REMU.
  - FSM state encoding: ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE, 3 bits.
  - Constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
- One sub-module, div_step: combinational single restoring-division iteration.
  - Inputs: rem[32:0], dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once inside ex_muldiv_unit.

Test Plan:
- MUL with EX_A=7, EX_B=0xFFFFFFFD (-3) -> md_stall=1 at cycles 0-1; md_done=1 at cycle 2 with md_result=0xFFFFFFEB and md_rd=EX_rd.
- MULH and MULHU with 0x80000000*0x80000000 -> MULH result 0x40000000, MULHU result 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD at cycle 34, md_stall high for exactly 34 cycles. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Flush: EX_flush=1 at cycle 10 of a DIV -> state IDLE at cycle 11, md_stall=0, no md_done pulse. A new MUL started at cycle 11 completes at cycle 13.
- Reset: reset=1 for one cycle at cycle 5 of a DIV -> all outputs 0 next cycle, no md_done. Also EX_flush and EX_md_valid together in IDLE -> md_stall=0, no start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and 32-bit boundary constants.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Purely combinational; no flow control.
module div_step (
  input  logic [32:0] rem,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] trial;

  // Remainder stays below the divisor, so bit 33 of the trial is a clean borrow flag.
  assign shifted  = {rem, dvd_msb};
  assign trial    = shifted - {2'b00, divisor};
  assign q_bit    = ~trial[33];
  assign rem_next = trial[33] ? shifted[32:0] : trial[32:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage, driving md_stall while busy.
// Latency: MUL* 2 cycles, DIV/REM 34 cycles, divide-by-zero/overflow 1 cycle.
// Backpressure: holds the pipeline via md_stall; EX_flush aborts an in-flight op.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EX_md_valid,
  input  logic            EX_flush,
  input  logic [2:0]      EX_funct3,
  input  logic [XLEN-1:0] EX_A,
  input  logic [XLEN-1:0] EX_B,
  input  logic [4:0]      EX_rd,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  md_state_t            state;
  logic [2:0]           f3_q;
  logic [4:0]           rd_q;
  logic [XLEN-1:0]      a_q, b_q;
  logic [XLEN-1:0]      dvd_q, dvs_q;
  logic [XLEN:0]        rem_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  logic start;
  assign start    = EX_md_valid && !EX_flush && (state == ST_IDLE);
  assign md_stall = start || (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);

  // 64-bit product of operands extended to 33 bits, computed modulo 2^64.
  logic            a_sext, b_sext;
  logic [63:0]     a64, b64, prod;
  logic [XLEN-1:0] mul_res;
  assign a_sext  = (f3_q != MD_MULHU);
  assign b_sext  = (f3_q == MD_MUL) || (f3_q == MD_MULH);
  assign a64     = {{32{a_sext & a_q[31]}}, a_q};
  assign b64     = {{32{b_sext & b_q[31]}}, b_q};
  assign prod    = a64 * b64;
  assign mul_res = (f3_q == MD_MUL) ? prod[31:0] : prod[63:32];

  logic            in_signed, in_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  assign in_signed = !EX_funct3[0];
  assign in_ovf    = in_signed && (EX_A == INT_MIN) && (EX_B == ALL_ONES);
  assign abs_a     = (in_signed && EX_A[31]) ? -EX_A : EX_A;
  assign abs_b     = (in_signed && EX_B[31]) ? -EX_B : EX_B;

  logic [XLEN:0] step_rem;
  logic          step_q;
  div_step u_div_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[XLEN-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  logic            fix_signed;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;
  assign fix_signed = !f3_q[0];
  assign q_fix   = (fix_signed && (a_q[31] ^ b_q[31])) ? -dvd_q : dvd_q;
  assign r_fix   = (fix_signed && a_q[31]) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign fix_res = f3_q[1] ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      f3_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      md_done   <= 1'b0;
      md_result <= '0;
      md_rd     <= '0;
    end else begin
      md_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            f3_q <= EX_funct3;
            rd_q <= EX_rd;
            a_q  <= EX_A;
            b_q  <= EX_B;
            if (!EX_funct3[2]) begin
              state <= ST_MUL;
            end else if (EX_B == '0) begin
              state     <= ST_DONE;
              md_done   <= 1'b1;
              md_rd     <= EX_rd;
              md_result <= EX_funct3[1] ? EX_A : ALL_ONES;
            end else if (in_ovf) begin
              state     <= ST_DONE;
              md_done   <= 1'b1;
              md_rd     <= EX_rd;
              md_result <= EX_funct3[1] ? '0 : INT_MIN;
            end else begin
              state <= ST_DIV;
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              rem_q <= '0;
              cnt_q <= DIV_CNT_W'(XLEN - 1);
            end
          end
        end
        ST_MUL: begin
          if (EX_flush) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_DONE;
            md_done   <= 1'b1;
            md_rd     <= rd_q;
            md_result <= mul_res;
          end
        end
        ST_DIV: begin
          if (EX_flush) begin
            state <= ST_IDLE;
          end else begin
            // Quotient bits shift into the vacated low end of the dividend register.
            rem_q <= step_rem;
            dvd_q <= {dvd_q[XLEN-2:0], step_q};
            cnt_q <= cnt_q - DIV_CNT_W'(1);
            if (cnt_q == '0) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (EX_flush) begin
            state <= ST_IDLE;
          end else begin
            state     <= ST_DONE;
            md_done   <= 1'b1;
            md_rd     <= rd_q;
            md_result <= fix_res;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec vectors, random ops
// against an arithmetic reference model, flush/reset/back-to-back scenarios.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_md_valid;
  logic        EX_flush;
  logic [2:0]  EX_funct3;
  logic [31:0] EX_A, EX_B;
  logic [4:0]  EX_rd;
  logic        md_stall, md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .DIV_CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .EX_md_valid (EX_md_valid),
    .EX_flush    (EX_flush),
    .EX_funct3   (EX_funct3),
    .EX_A        (EX_A),
    .EX_B        (EX_B),
    .EX_rd       (EX_rd),
    .md_stall    (md_stall),
    .md_done     (md_done),
    .md_result   (md_result),
    .md_rd       (md_rd)
  );

  // Reference: RV32M semantics expressed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drives one op and measures it; 'now' starts in the current cycle instead of the next.
  task automatic issue_op(input bit now, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int stall_cyc,
                          output logic [31:0] res, output logic [4:0] rdo);
    if (!now) @(negedge clk);
    EX_md_valid = 1'b1;
    EX_funct3   = f3;
    EX_A        = a;
    EX_B        = b;
    EX_rd       = rd;
    lat = -1; stall_cyc = 0; res = 'x; rdo = 'x;
    for (int c = 0; c < 60 && lat < 0; c++) begin
      #1;
      if (md_stall) stall_cyc++;
      if (md_done) begin
        lat = c; res = md_result; rdo = md_rd;
      end else begin
        @(negedge clk);
      end
    end
    EX_md_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; EX_md_valid = 1'b0; EX_flush = 1'b0;
    EX_funct3 = '0; EX_A = '0; EX_B = '0; EX_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({md_done, md_stall, md_result, md_rd} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_state: done=%b stall=%b result=%h rd=%0d, required all zero",
               md_done, md_stall, md_result, md_rd);
    end
  endtask

  logic [2:0]  d_f3  [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4};
  logic [31:0] d_a   [13] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5};
  logic [31:0] d_b   [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] d_exp [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                              32'hFFFF_FFFF};
  int          d_lat [13] = '{2, 2, 2, 2, 34, 34, 34, 34, 1, 1, 1, 1, 1};

  task automatic test_directed();
    int lat, st; logic [31:0] res; logic [4:0] rdo;
    for (int i = 0; i < 13; i++) begin
      issue_op(1'b0, d_f3[i], d_a[i], d_b[i], 5'(i + 1), lat, st, res, rdo);
      n_checks++;
      if (res !== d_exp[i] || rdo !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL directed_%0d result: f3=%0d a=%h b=%h got %h rd %0d, required %h rd %0d",
                 i, d_f3[i], d_a[i], d_b[i], res, rdo, d_exp[i], i + 1);
      end
      n_checks++;
      if (lat != d_lat[i] || st != d_lat[i]) begin
        n_fail++;
        $display("FAIL directed_%0d timing: done at %0d stall cycles %0d, required %0d/%0d",
                 i, lat, st, d_lat[i], d_lat[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, st; logic [31:0] res, a, b, exp; logic [4:0] rdo, rd; logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      rd  = 5'($urandom);
      exp = ref_result(f3, a, b);
      issue_op(1'b0, f3, a, b, rd, lat, st, res, rdo);
      n_checks++;
      if (res !== exp || rdo !== rd || lat != ref_latency(f3, a, b) || st != lat) begin
        n_fail++;
        $display("FAIL random_%0d: f3=%0d a=%h b=%h got %h rd %0d lat %0d stall %0d, required %h rd %0d lat %0d",
                 i, f3, a, b, res, rdo, lat, st, exp, rd, ref_latency(f3, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, st; logic [31:0] res; logic [4:0] rdo;
    logic [2:0]  f3[3] = '{3'd0, 3'd5, 3'd3};
    logic [31:0] a[3]  = '{32'd123, 32'd1000, 32'hFFFF_FFFF};
    logic [31:0] b[3]  = '{32'd456, 32'd33, 32'h2};
    for (int i = 0; i < 3; i++) begin
      issue_op(1'b0, f3[i], a[i], b[i], 5'(20 + i), lat, st, res, rdo);
      n_checks++;
      if (res !== ref_result(f3[i], a[i], b[i]) || lat != ref_latency(f3[i], a[i], b[i])) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %h at %0d, required %h at %0d",
                 i, res, lat, ref_result(f3[i], a[i], b[i]), ref_latency(f3[i], a[i], b[i]));
      end
    end
  endtask

  task automatic test_flush();
    int lat, st, seen; logic [31:0] res; logic [4:0] rdo;
    seen = 0;
    @(negedge clk);
    EX_md_valid = 1'b1; EX_funct3 = MD_DIVU; EX_A = 32'd1000; EX_B = 32'd3; EX_rd = 5'd9;
    for (int c = 0; c < 10; c++) begin
      #1; if (md_done) seen++;
      @(negedge clk);
    end
    EX_flush = 1'b1;
    #1; if (md_done) seen++;
    @(negedge clk);
    EX_flush = 1'b0; EX_md_valid = 1'b0;
    #1;
    n_checks++;
    if (md_stall !== 1'b0 || md_done !== 1'b0 || seen != 0) begin
      n_fail++;
      $display("FAIL flush_abort: stall=%b done=%b early_done=%0d, required 0/0/0", md_stall, md_done, seen);
    end
    issue_op(1'b1, MD_MUL, 32'd6, 32'd7, 5'd12, lat, st, res, rdo);
    n_checks++;
    if (res !== 32'd42 || rdo !== 5'd12 || lat != 2) begin
      n_fail++;
      $display("FAIL flush_restart: got %h rd %0d at %0d, required 0000002a rd 12 at 2", res, rdo, lat);
    end
  endtask

  task automatic test_idle_flush();
    int bad;
    bad = 0;
    @(negedge clk);
    EX_md_valid = 1'b1; EX_flush = 1'b1; EX_funct3 = MD_MUL; EX_A = 32'd3; EX_B = 32'd3; EX_rd = 5'd4;
    for (int c = 0; c < 4; c++) begin
      #1; if (md_stall || md_done) bad++;
      @(negedge clk);
    end
    EX_md_valid = 1'b0; EX_flush = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_flush_wins: %0d cycles with stall/done, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    seen = 0;
    @(negedge clk);
    EX_md_valid = 1'b1; EX_funct3 = MD_DIV; EX_A = 32'hFFFF_0000; EX_B = 32'd77; EX_rd = 5'd30;
    for (int c = 0; c < 5; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; EX_md_valid = 1'b0;
    #1;
    n_checks++;
    if ({md_done, md_stall, md_result, md_rd} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: done=%b stall=%b result=%h rd=%0d, required all zero",
               md_done, md_stall, md_result, md_rd);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1; if (md_done) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_discard: %0d md_done pulses after reset, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_idle_flush();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
